// File: rtl/sprite_blitter.sv
// Pixel-stream generator for the VGA plot path: full background redraw, or
// sprite move (restore background under the old rectangle, then draw the sprite).
module sprite_blitter #(
    parameter int             SCR_W      = 160,
    parameter int             SCR_H      = 120,
    parameter int             SPR_W      = 9,
    parameter int             SPR_H      = 9,
    parameter int             CW         = 3,
    parameter int             ROM_LAT    = 1,
    parameter logic [CW-1:0]  TRANSP_KEY = CW'(3'b101),
    localparam int            XW         = $clog2(SCR_W),
    localparam int            YW         = $clog2(SCR_H),
    localparam int            BAW        = $clog2(SCR_W * SCR_H),
    localparam int            SAW        = $clog2(SPR_W * SPR_H)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           mode,
    input  logic [XW-1:0]  spr_x,
    input  logic [YW-1:0]  spr_y,
    output logic           busy,
    output logic           done,
    output logic [BAW-1:0] bg_addr,
    input  logic [CW-1:0]  bg_data,
    output logic [SAW-1:0] spr_addr,
    input  logic [CW-1:0]  spr_data,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic [CW-1:0]  colour,
    output logic           plot
);

    localparam int CXW = ($clog2(SPR_W) > XW) ? $clog2(SPR_W) : XW;
    localparam int CYW = ($clog2(SPR_H) > YW) ? $clog2(SPR_H) : YW;
    localparam int FW  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {IDLE, FULL, ERASE, DRAW, FLUSH, DONE} state_t;

    typedef struct packed {
        logic          v;
        logic          spr;
        logic          clip;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } pix_t;

    state_t          state, state_nxt;
    logic            cmd_mode;
    logic [XW-1:0]   cmd_x, old_x;
    logic [YW-1:0]   cmd_y, old_y;
    logic            old_valid;
    logic [CXW-1:0]  ix;
    logic [CYW-1:0]  iy;
    logic [FW-1:0]   fl_cnt;

    logic            scanning, x_last, y_last, accept, eff_old_valid;
    logic [XW:0]     px;
    logic [YW:0]     py;
    logic            clip;
    pix_t            issue;
    pix_t            pipe [ROM_LAT];
    pix_t            tail;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_nxt     = state;
        scanning      = (state == FULL) || (state == ERASE) || (state == DRAW);
        x_last        = (state == FULL) ? (ix == CXW'(SCR_W - 1)) : (ix == CXW'(SPR_W - 1));
        y_last        = (state == FULL) ? (iy == CYW'(SCR_H - 1)) : (iy == CYW'(SPR_H - 1));
        accept        = start && ((state == IDLE) || (state == DONE));
        // In DONE the finishing command's bookkeeping has not landed yet.
        eff_old_valid = (state == DONE) ? cmd_mode : old_valid;

        case (state)
            IDLE, DONE: begin
                if (start)
                    state_nxt = mode ? (eff_old_valid ? ERASE : DRAW) : FULL;
                else
                    state_nxt = IDLE;
            end
            FULL, DRAW: if (x_last && y_last) state_nxt = FLUSH;
            ERASE:      if (x_last && y_last) state_nxt = DRAW;
            FLUSH:      if (fl_cnt == FW'(ROM_LAT - 1)) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Sums are one bit wider than the screen coordinate so off-screen pixels are clipped, not wrapped.
    always_comb begin
        case (state)
            ERASE: begin
                px = {1'b0, old_x} + (XW+1)'(ix);
                py = {1'b0, old_y} + (YW+1)'(iy);
            end
            DRAW: begin
                px = {1'b0, cmd_x} + (XW+1)'(ix);
                py = {1'b0, cmd_y} + (YW+1)'(iy);
            end
            default: begin
                px = (XW+1)'(ix);
                py = (YW+1)'(iy);
            end
        endcase
        clip       = (px >= (XW+1)'(SCR_W)) || (py >= (YW+1)'(SCR_H));
        issue.v    = scanning;
        issue.spr  = (state == DRAW);
        issue.clip = clip;
        issue.x    = px[XW-1:0];
        issue.y    = py[YW-1:0];
    end

    assign bg_addr  = ((state == FULL) || (state == ERASE))
                    ? BAW'(py) * BAW'(SCR_W) + BAW'(px) : '0;
    assign spr_addr = (state == DRAW) ? SAW'(iy) * SAW'(SPR_W) + SAW'(ix) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmd_mode  <= 1'b0;
            cmd_x     <= '0;
            cmd_y     <= '0;
            old_valid <= 1'b0;
            old_x     <= '0;
            old_y     <= '0;
        end else begin
            if (state == DONE) begin
                old_valid <= cmd_mode;
                if (cmd_mode) begin
                    old_x <= cmd_x;
                    old_y <= cmd_y;
                end
            end
            if (accept) begin
                cmd_mode <= mode;
                cmd_x    <= spr_x;
                cmd_y    <= spr_y;
            end
        end
    end

    // Scan counters wrap to zero at the end of each rectangle, ready for the next scan.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ix     <= '0;
            iy     <= '0;
            fl_cnt <= '0;
        end else begin
            if (scanning) begin
                if (x_last) begin
                    ix <= '0;
                    iy <= y_last ? '0 : iy + 1'b1;
                end else begin
                    ix <= ix + 1'b1;
                end
            end else begin
                ix <= '0;
                iy <= '0;
            end
            fl_cnt <= (state == FLUSH) ? fl_cnt + 1'b1 : '0;
        end
    end

    // NOTE: the delay line is reset so an abandoned command cannot leak a stale plot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= issue;
            for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail   = pipe[ROM_LAT-1];
    assign x      = tail.x;
    assign y      = tail.y;
    assign colour = !tail.v ? '0 : (tail.spr ? spr_data : bg_data);
    assign plot   = tail.v && !tail.clip && !(tail.spr && (spr_data == TRANSP_KEY));
    assign busy   = (state == FULL) || (state == ERASE) || (state == DRAW) || (state == FLUSH);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: per-command expectations built from a list of issued
// pixels, compared cycle by cycle against the DUT's plot/handshake outputs.
module tb_sprite_blitter;

    localparam int SCR_W   = 8;
    localparam int SCR_H   = 4;
    localparam int SPR_W   = 3;
    localparam int SPR_H   = 3;
    localparam int CW      = 3;
    localparam int ROM_LAT = 2;
    localparam int KEY     = 5;
    localparam int XW      = $clog2(SCR_W);
    localparam int YW      = $clog2(SCR_H);
    localparam int BAW     = $clog2(SCR_W * SCR_H);
    localparam int SAW     = $clog2(SPR_W * SPR_H);
    localparam int MAXC    = 64;

    logic           clk = 1'b0;
    logic           resetn;
    logic           start;
    logic           mode;
    logic [XW-1:0]  spr_x;
    logic [YW-1:0]  spr_y;
    logic           busy, done, plot;
    logic [BAW-1:0] bg_addr;
    logic [SAW-1:0] spr_addr;
    logic [CW-1:0]  bg_data, spr_data, colour;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;

    int checks = 0;
    int errors = 0;

    sprite_blitter #(
        .SCR_W(SCR_W), .SCR_H(SCR_H), .SPR_W(SPR_W), .SPR_H(SPR_H),
        .CW(CW), .ROM_LAT(ROM_LAT), .TRANSP_KEY(3'b101)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode),
        .spr_x(spr_x), .spr_y(spr_y), .busy(busy), .done(done),
        .bg_addr(bg_addr), .bg_data(bg_data), .spr_addr(spr_addr), .spr_data(spr_data),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    // ROMs: data = address[2:0], available ROM_LAT cycles after the address.
    logic [BAW-1:0] bg_q [ROM_LAT];
    logic [SAW-1:0] sp_q [ROM_LAT];
    always @(posedge clk) begin
        bg_q[0] <= bg_addr;
        sp_q[0] <= spr_addr;
        for (int i = 1; i < ROM_LAT; i++) begin
            bg_q[i] <= bg_q[i-1];
            sp_q[i] <= sp_q[i-1];
        end
    end
    assign bg_data  = bg_q[ROM_LAT-1][2:0];
    assign spr_data = sp_q[ROM_LAT-1][2:0];

    // Reference model state and per-cycle expectations of the current command.
    bit m_old_valid;
    int m_old_x, m_old_y;
    int n_issue, e_done;
    bit e_plot [MAXC];
    int e_x [MAXC], e_y [MAXC], e_c [MAXC];
    int e_kind [MAXC];
    bit e_aon [MAXC];
    int e_addr [MAXC];

    task automatic add_pix(input int kind, input int px, input int py, input int saddr);
        int ic, oc, col;
        bit on;
        ic  = n_issue + 1;
        oc  = ic + ROM_LAT;
        on  = (px < SCR_W) && (py < SCR_H);
        col = (kind == 1) ? (py * SCR_W + px) % 8 : saddr % 8;
        e_kind[ic] = kind;
        e_aon[ic]  = on;
        e_addr[ic] = (kind == 1) ? py * SCR_W + px : saddr;
        e_plot[oc] = on && !(kind == 2 && col == KEY);
        e_x[oc]    = px;
        e_y[oc]    = py;
        e_c[oc]    = col;
        n_issue++;
    endtask

    task automatic build(input logic m, input int sx, input int sy);
        for (int i = 0; i < MAXC; i++) begin
            e_plot[i] = 1'b0; e_kind[i] = 0; e_aon[i] = 1'b0;
            e_x[i] = 0; e_y[i] = 0; e_c[i] = 0; e_addr[i] = 0;
        end
        n_issue = 0;
        if (!m) begin
            for (int yy = 0; yy < SCR_H; yy++)
                for (int xx = 0; xx < SCR_W; xx++) add_pix(1, xx, yy, 0);
        end else begin
            if (m_old_valid)
                for (int r = 0; r < SPR_H; r++)
                    for (int c = 0; c < SPR_W; c++) add_pix(1, m_old_x + c, m_old_y + r, 0);
            for (int r = 0; r < SPR_H; r++)
                for (int c = 0; c < SPR_W; c++) add_pix(2, sx + c, sy + r, r * SPR_W + c);
        end
        e_done = n_issue + ROM_LAT + 1;
    endtask

    // Issues one command at the current negedge and checks every cycle up to DONE.
    task automatic run_cmd(input logic m, input int sx, input int sy,
                           input int pulse_at, input int abort_at, input bit keep_start);
        logic eb, ed;
        build(m, sx, sy);
        mode  = m;
        spr_x = XW'(sx);
        spr_y = YW'(sy);
        start = 1'b1;
        for (int k = 1; k <= e_done; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                resetn = 1'b0;
                #1;
                checks++;
                if ({busy, done, plot} !== 3'b000 || bg_addr !== '0 || spr_addr !== '0 ||
                    x !== '0 || y !== '0 || colour !== '0) begin
                    errors++;
                    $display("FAIL reset_mid: busy=%0b done=%0b plot=%0b bg_addr=%0d spr_addr=%0d x=%0d y=%0d colour=%0d, expected all 0",
                             busy, done, plot, bg_addr, spr_addr, x, y, colour);
                end
                start       = 1'b0;
                m_old_valid = 1'b0;
                m_old_x     = 0;
                m_old_y     = 0;
                repeat (2) @(negedge clk);
                resetn = 1'b1;
                @(negedge clk);
                return;
            end
            eb = (k < e_done);
            ed = (k == e_done);
            checks++;
            if ({busy, done} !== {eb, ed}) begin
                errors++;
                $display("FAIL handshake cycle %0d: busy=%0b done=%0b, expected busy=%0b done=%0b",
                         k, busy, done, eb, ed);
            end
            checks++;
            if (plot !== e_plot[k]) begin
                errors++;
                $display("FAIL plot cycle %0d: plot=%0b at (%0d,%0d), expected %0b", k, plot, x, y, e_plot[k]);
            end else if (e_plot[k]) begin
                checks++;
                if (x !== XW'(e_x[k]) || y !== YW'(e_y[k]) || colour !== CW'(e_c[k])) begin
                    errors++;
                    $display("FAIL pixel cycle %0d: (%0d,%0d) colour %0d, expected (%0d,%0d) colour %0d",
                             k, x, y, colour, e_x[k], e_y[k], e_c[k]);
                end
            end
            if (e_kind[k] == 0) begin
                checks++;
                if (bg_addr !== '0 || spr_addr !== '0) begin
                    errors++;
                    $display("FAIL addr_idle cycle %0d: bg_addr=%0d spr_addr=%0d, expected 0 and 0", k, bg_addr, spr_addr);
                end
            end else if (e_aon[k]) begin
                checks++;
                if ((e_kind[k] == 1 && bg_addr !== BAW'(e_addr[k])) ||
                    (e_kind[k] == 2 && spr_addr !== SAW'(e_addr[k]))) begin
                    errors++;
                    $display("FAIL addr cycle %0d: bg_addr=%0d spr_addr=%0d, expected %s address %0d",
                             k, bg_addr, spr_addr, (e_kind[k] == 1) ? "bg" : "spr", e_addr[k]);
                end
            end
            if (k < e_done) begin
                start = (k == pulse_at);
                if (k == pulse_at) begin
                    mode  = 1'($urandom_range(0, 1));
                    spr_x = XW'($urandom_range(0, SCR_W - 1));
                    spr_y = YW'($urandom_range(0, SCR_H - 1));
                end
            end
        end
        m_old_valid = m;
        if (m) begin
            m_old_x = sx;
            m_old_y = sy;
        end
        if (!keep_start) begin
            start = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy, done, plot} !== 3'b000) begin
                errors++;
                $display("FAIL idle_after: busy=%0b done=%0b plot=%0b, expected all 0", busy, done, plot);
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        start  = 1'b0;
        mode   = 1'b0;
        spr_x  = '0;
        spr_y  = '0;
        m_old_valid = 1'b0;
        m_old_x = 0;
        m_old_y = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, plot} !== 3'b000 || bg_addr !== '0 || spr_addr !== '0 ||
            x !== '0 || y !== '0 || colour !== '0) begin
            errors++;
            $display("FAIL reset: busy=%0b done=%0b plot=%0b bg_addr=%0d spr_addr=%0d x=%0d y=%0d colour=%0d, expected all 0",
                     busy, done, plot, bg_addr, spr_addr, x, y, colour);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_redraw;
        run_cmd(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_sprite_moves;
        run_cmd(1'b1, 2, 1, 0, 0, 1'b0);
        run_cmd(1'b1, 4, 0, 0, 0, 1'b0);
    endtask

    task automatic test_clip;
        run_cmd(1'b1, 7, 3, 0, 0, 1'b0);
    endtask

    task automatic test_busy_ignore;
        run_cmd(1'b1, 1, 1, 5, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_cmd(1'b0, 0, 0, 0, 0, 1'b1);
        run_cmd(1'b1, 3, 2, 0, 0, 1'b1);
        run_cmd(1'b1, 6, 2, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        run_cmd(1'b1, 0, 0, 0, 0, 1'b0);
        run_cmd(1'b0, 0, 0, 0, 10, 1'b0);
        run_cmd(1'b1, 5, 1, 0, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++)
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, SCR_W - 1)),
                    int'($urandom_range(0, SCR_H - 1)), 0, 0,
                    (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    initial begin
        test_reset;
        test_full_redraw;
        test_sprite_moves;
        test_clip;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised pixel-stream generator for the VGA plot path.
- Redraws the full background from a background ROM on command.
- Moves a sprite on command: first restores the background under the sprite's previous rectangle, then draws the sprite at a new position.
- Adds colour-key transparency, screen-edge clipping, configurable ROM read latency and a start/busy/done handshake to the game's control FSM.

Parameters:
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels
- SPR_W, 9, sprite width
- SPR_H, 9, sprite height
- CW, 3, colour width in bits
- ROM_LAT, 1, read latency of both ROMs in cycles (>=1)
- TRANSP_KEY, 3'b101, sprite colour treated as transparent (CW bits)
- XW = clog2(SCR_W), YW = clog2(SCR_H), BAW = clog2(SCR_W*SCR_H), SAW = clog2(SPR_W*SPR_H): derived widths

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  command request, sampled each rising edge
- mode  in  1  0 = full background redraw, 1 = sprite move; sampled with start
- spr_x  in  XW  new sprite top-left x; sampled with start
- spr_y  in  YW  new sprite top-left y; sampled with start
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- bg_addr  out  BAW  background ROM address = y*SCR_W + x
- bg_data  in  CW  background ROM data, valid ROM_LAT cycles after address
- spr_addr  out  SAW  sprite ROM address = row*SPR_W + col
- spr_data  in  CW  sprite ROM data, valid ROM_LAT cycles after address
- x  out  XW  plot x
- y  out  YW  plot y
- colour  out  CW  plot colour
- plot  out  1  write enable to the VGA adapter

Behaviour:
- Reset (async, resetn=0):
  - busy, done, plot, x, y, colour, bg_addr and spr_addr go to 0.
  - FSM goes to IDLE; old_valid, old_x and old_y go to 0.
  - Reset mid-command abandons the command; no done is issued.
- States: IDLE, FULL, ERASE, DRAW, FLUSH, DONE.
- Accept:
  - In IDLE with start=1 at edge E0: latch mode, spr_x and spr_y; busy=1 from E0.
  - start while busy=1 is ignored.
  - Cycle k means the k-th clock period after E0.
- FULL:
  - Raster scan x 0..SCR_W-1 inner, y 0..SCR_H-1 outer.
  - One bg_addr per cycle in cycles 1..N, where N = SCR_W*SCR_H.
- ERASE: entered for mode=1 only when old_valid=1.
  - Scan col 0..SPR_W-1 inner, row 0..SPR_H-1 outer.
  - bg_addr addresses (old_x+col, old_y+row).
- DRAW: same scan at (spr_x+col, spr_y+row), driving spr_addr.
  - If old_valid=0, DRAW starts in cycle 1.
  - Otherwise DRAW addresses follow ERASE back-to-back with no gap cycle.
- Pipeline:
  - Coordinates and a valid/kind tag travel through a ROM_LAT-deep delay line alongside each address.
  - Registered outputs: in cycle c+ROM_LAT, x and y equal the coordinates issued in cycle c.
  - colour takes bg_data or spr_data accordingly.
  - plot=1 unless suppressed.
- Suppression (plot=0; x, y and colour don't-care):
  - Any ERASE/DRAW pixel with x >= SCR_W or y >= SCR_H (clipping, no wrap).
  - Coordinate sums are computed at XW+1 / YW+1 bits so overflow is detected, not wrapped.
  - DRAW pixels whose spr_data == TRANSP_KEY.
  - Suppressed pixels still consume their cycle.
- FLUSH: holds ROM_LAT cycles after the last address to drain the pipeline.
- DONE:
  - One cycle with done=1 and busy=0; this is cycle M+ROM_LAT+1, where M is the total addresses issued.
  - start in the DONE cycle is accepted.
- Bookkeeping at DONE:
  - mode=1: old_x <= spr_x, old_y <= spr_y, old_valid <= 1.
  - mode=0: old_valid <= 0, since the full redraw already covered the old sprite.
- Outside address-issue cycles, bg_addr and spr_addr hold 0. plot=0 whenever no valid pixel exits the pipeline.

Test Plan:
(Configuration: SCR_W=8, SCR_H=4, SPR_W=SPR_H=3, ROM_LAT=2; ROMs return address[2:0]; TRANSP_KEY=3'b101.)
- Full redraw: start, mode=0 -> plot high in cycles 3..34 in raster order (x,y)=(0,0)..(7,3), colour=(y*8+x)%8; done pulses in cycle 35; busy low in cycle 35.
- First sprite move at (2,1), old_valid=0 -> 9 DRAW addresses in cycles 1..9, plot in cycles 3..11. Sprite address 5 is transparent, so no plot at (4,2). done in cycle 12.
- Second move to (4,0) -> ERASE plots (2..4,1..3) with background colours in cycles 3..11; DRAW plots (4..6,0..2) in cycles 12..20 except (6,1); done in cycle 21.
- Clipping: move to (7,3) -> only (7,3) is plotted in DRAW; all off-screen cycles have plot=0; done timing is unchanged at cycle 21.
- start pulsed at cycle 5 of a busy command -> ignored, no extra done. start held through the DONE cycle -> new command accepted at that edge.
- resetn asserted low at cycle 10 of a full redraw -> plot, busy and done are 0 immediately. After release, a mode=1 command performs no ERASE.
